button_conditioner: RTL and testbench

// - Front-end for the alarm clock. Takes the three raw active-low board push-buttons
//   (start/stop, set, snooze): synchronises, debounces and classifies each one.
// - Outputs clean active-high levels and single-cycle press, release, long-press and

---
 rtl/button_conditioner.sv | 219 +++++++++++++++++++++
 tb/tb_button_conditioner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Alarm-clock button front end: 2-FF sync, debounce and press/release/long/repeat pulses.
// Optional auto-repeat is built when BUTTON_AUTO_REPEAT_EN is defined.

module button_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000,
    parameter int unsigned REPEAT_CYCLES     = 12500000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic sync,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng,
    output logic rpt
);
    localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          from_held_q, from_held_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          lng_q, lng_d;

    always_comb begin
        cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        from_held_d = from_held_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        lng_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CW'(1);
                end
            end
            DEB_PRESS: begin
                if (sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                // The press-accept cycle is the first held cycle, so test the incremented count.
                if (sync) begin
                    state_d     = DEB_RELEASE;
                    cnt_d       = CW'(1);
                    from_held_d = 1'b0;
                end else if (cnt_inc == CW'(LONG_PRESS_CYCLES)) begin
                    state_d = HELD;
                    lng_d   = 1'b1;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (sync) begin
                    state_d     = DEB_RELEASE;
                    cnt_d       = CW'(1);
                    from_held_d = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (!sync) begin
                    state_d = from_held_q ? HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            from_held_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            lng_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_held_q <= from_held_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            lng_q       <= lng_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign lng   = lng_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic          rpt_q, rpt_d;

    always_comb begin
        rpt_inc   = rpt_cnt_q + 1'b1;
        rpt_cnt_d = rpt_cnt_q;
        rpt_d     = 1'b0;
        // Frozen while a release is being debounced so a bounce back to HELD keeps cadence.
        if (state_q == HELD && !sync) begin
            if (rpt_inc == RW'(REPEAT_CYCLES)) begin
                rpt_d     = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_inc;
            end
        end else if (state_q != DEB_RELEASE) begin
            rpt_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = (REPEAT_CYCLES == 0) && 1'b0;
`endif
endmodule

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000,
    parameter int unsigned REPEAT_CYCLES     = 12500000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [2:0] btn_n_in,
    output logic [2:0] btn_level,
    output logic [2:0] press_pulse,
    output logic [2:0] release_pulse,
    output logic [2:0] long_pulse,
    output logic [2:0] rpt_pulse
);
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_n_in;
        sync2_d = sync1_q;
    end

    // Synchroniser resets to "released" so a held button is seen as a fresh press.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_fsm #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_fsm (
            .CLK  (CLK),
            .rst_n(rst_n),
            .sync (sync2_q[i]),
            .level(btn_level[i]),
            .press(press_pulse[i]),
            .rel  (release_pulse[i]),
            .lng  (long_pulse[i]),
            .rpt  (rpt_pulse[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, LONG_PRESS=20, REPEAT=5.
module tb_button_conditioner;
    logic       CLK;
    logic       rst_n;
    logic [2:0] btn_n_in;
    logic [2:0] btn_level, press_pulse, release_pulse, long_pulse, rpt_pulse;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_CYCLES    (5)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .btn_n_in     (btn_n_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .rpt_pulse    (rpt_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input logic [2:0] lvl,
                           input logic [2:0] prs, input logic [2:0] rel,
                           input logic [2:0] lng, input logic [2:0] rpt);
        chk($sformatf("%s[%0d]/level", tag, e), btn_level, lvl);
        chk($sformatf("%s[%0d]/press", tag, e), press_pulse, prs);
        chk($sformatf("%s[%0d]/release", tag, e), release_pulse, rel);
        chk($sformatf("%s[%0d]/long", tag, e), long_pulse, lng);
        chk($sformatf("%s[%0d]/rpt", tag, e), rpt_pulse, rpt);
    endtask

    // Advance one rising edge and sample 1 ns later; edge index e counts from the
    // first edge that samples the newly driven input.
    task automatic step_chk(input string tag, input int e, input logic [2:0] lvl,
                            input logic [2:0] prs, input logic [2:0] rel,
                            input logic [2:0] lng, input logic [2:0] rpt);
        @(posedge CLK);
        #1;
        chk_all(tag, e, lvl, prs, rel, lng, rpt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] er;
        btn_n_in = 3'b111;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all("reset", 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int e = 0; e < 3; e++) step_chk("reset_hold", e, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) step_chk("idle", e, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

        // Clean press on set, held 10 edges, then released.
        btn_n_in = 3'b101;
        for (int e = 0; e < 10; e++)
            step_chk("clean", e, (e >= 6) ? 3'b010 : 3'b000, (e == 6) ? 3'b010 : 3'b000,
                     3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b111;
        for (int e = 0; e < 8; e++)
            step_chk("clean_rel", e, (e < 6) ? 3'b010 : 3'b000, 3'b000,
                     (e == 6) ? 3'b010 : 3'b000, 3'b000, 3'b000);

        // Bounce on start_stop: low 3, high 1, then low steady from edge 4.
        btn_n_in = 3'b110;
        for (int e = 0; e < 3; e++) step_chk("bounce", e, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b111;
        step_chk("bounce", 3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b110;
        for (int e = 4; e < 16; e++)
            step_chk("bounce", e, (e >= 10) ? 3'b001 : 3'b000, (e == 10) ? 3'b001 : 3'b000,
                     3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b111;
        for (int e = 0; e < 8; e++)
            step_chk("bounce_rel", e, (e < 6) ? 3'b001 : 3'b000, 3'b000,
                     (e == 6) ? 3'b001 : 3'b000, 3'b000, 3'b000);

        // Long hold on snooze for 40 edges.
        btn_n_in = 3'b011;
        for (int e = 0; e < 52; e++) begin
            if (e == 40) btn_n_in = 3'b111;
`ifdef BUTTON_AUTO_REPEAT_EN
            er = (e == 31 || e == 36 || e == 41) ? 3'b100 : 3'b000;
`else
            er = 3'b000;
`endif
            step_chk("long", e, (e >= 6 && e < 46) ? 3'b100 : 3'b000,
                     (e == 6) ? 3'b100 : 3'b000, (e == 46) ? 3'b100 : 3'b000,
                     (e == 26) ? 3'b100 : 3'b000, er);
        end

        // All three pressed and released on the same edge.
        btn_n_in = 3'b000;
        for (int e = 0; e < 8; e++)
            step_chk("simul", e, (e >= 6) ? 3'b111 : 3'b000, (e == 6) ? 3'b111 : 3'b000,
                     3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b111;
        for (int e = 0; e < 8; e++)
            step_chk("simul_rel", e, (e < 6) ? 3'b111 : 3'b000, 3'b000,
                     (e == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000);

        // Reset while start_stop is debouncing and set is already accepted.
        btn_n_in = 3'b101;
        for (int e = 0; e < 8; e++)
            step_chk("rst_pre", e, (e >= 6) ? 3'b010 : 3'b000, (e == 6) ? 3'b010 : 3'b000,
                     3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b100;
        for (int e = 0; e < 4; e++) step_chk("rst_deb", e, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int e = 0; e < 2; e++) step_chk("rst_mid", e, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++)
            step_chk("rst_post", e, (e >= 6) ? 3'b011 : 3'b000, (e == 6) ? 3'b011 : 3'b000,
                     3'b000, 3'b000, 3'b000);
        btn_n_in = 3'b111;
        for (int e = 0; e < 8; e++)
            step_chk("rst_rel", e, (e < 6) ? 3'b011 : 3'b000, 3'b000,
                     (e == 6) ? 3'b011 : 3'b000, 3'b000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
